// File: rtl/atm_session_ctrl.sv
// Session sequencer for the ATM datapath: turns button presses into a one-hot
// screen state and a ready strobe, and tracks login, PIN retries, timeout and hold.
module atm_session_ctrl #(
    parameter int MAX_PIN_TRIES  = 3,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int HOLD_CYCLES    = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ready_btn,
    input  logic        exit_btn,
    input  logic [1:0]  menu_option,
    input  logic [3:0]  status_code_in,
    output logic [15:0] current_state,
    output logic        ready_out,
    output logic        session_active,
    output logic [1:0]  pin_tries_left,
    output logic [3:0]  last_status,
    output logic        timeout_flag
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]       TRIES_INIT   = 2'(MAX_PIN_TRIES);

    localparam logic [3:0] ST_ACC_FOUND     = 4'd1;
    localparam logic [3:0] ST_ACC_NOT_FOUND = 4'd2;
    localparam logic [3:0] ST_PIN_CORRECT   = 4'd3;
    localparam logic [3:0] ST_PIN_INCORRECT = 4'd4;
    localparam logic [3:0] ST_AMT_VALID     = 4'd5;
    localparam logic [3:0] ST_AMT_INVALID   = 4'd6;

    typedef enum logic [15:0] {
        S_IDLE       = 16'h0001,
        S_ACC_NUM    = 16'h0002,
        S_PIN_INPUT  = 16'h0004,
        S_MENU       = 16'h0008,
        S_SHOW_BAL   = 16'h0010,
        S_CONVERT    = 16'h0020,
        S_SEL_CONV_1 = 16'h0040,
        S_SEL_CONV_2 = 16'h0080,
        S_WITHDRAW   = 16'h0100,
        S_SEL_AMT_WD = 16'h0200,
        S_TRANSFER   = 16'h0400,
        S_SEL_CUR_TR = 16'h0800,
        S_SEL_AMT_TR = 16'h1000,
        S_ERROR      = 16'h2000,
        S_SUCCESS    = 16'h4000
    } state_e;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             session_q, session_d;
    logic [1:0]       tries_q, tries_d;
    logic [3:0]       last_q, last_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_prev_q, exit_prev_q;
    logic             ready_q, exit_q;

    logic             in_hold, counted, timed_out, hold_done;
    logic [1:0]       tries_dec;

    assign in_hold   = (state_q == S_ERROR) || (state_q == S_SUCCESS);
    assign counted   = !in_hold && (state_q != S_IDLE);
    assign timed_out = counted && (cnt_q >= TIMEOUT_LAST);
    assign hold_done = in_hold && (cnt_q >= HOLD_LAST);
    assign tries_dec = (tries_q != 2'd0) ? tries_q - 2'd1 : 2'd0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        pending_d = pending_q;
        session_d = session_q;
        tries_d   = tries_q;
        last_d    = last_q;
        timeout_d = 1'b0;

        if (exit_q && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
        end else if (timed_out) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            timeout_d = 1'b1;
        end else if (pending_q) begin
            // Status returned by the datapath for the strobe issued one cycle earlier.
            pending_d = 1'b0;
            case (state_q)
                S_ACC_NUM, S_TRANSFER: begin
                    if (status_code_in == ST_ACC_FOUND) begin
                        state_d = (state_q == S_ACC_NUM) ? S_PIN_INPUT : S_SEL_CUR_TR;
                        last_d  = status_code_in;
                    end else if (status_code_in == ST_ACC_NOT_FOUND) begin
                        state_d = S_ERROR;
                        last_d  = status_code_in;
                    end
                end
                S_PIN_INPUT: begin
                    if (status_code_in == ST_PIN_CORRECT) begin
                        state_d   = S_MENU;
                        session_d = 1'b1;
                        tries_d   = TRIES_INIT;
                        last_d    = status_code_in;
                    end else if (status_code_in == ST_PIN_INCORRECT) begin
                        tries_d = tries_dec;
                        state_d = (tries_dec == 2'd0) ? S_ERROR : S_PIN_INPUT;
                        last_d  = status_code_in;
                    end
                end
                S_SEL_CONV_1, S_SEL_AMT_WD, S_SEL_AMT_TR: begin
                    if (status_code_in == ST_AMT_VALID) begin
                        state_d = (state_q == S_SEL_CONV_1) ? S_SEL_CONV_2 : S_SUCCESS;
                        last_d  = status_code_in;
                    end else if (status_code_in == ST_AMT_INVALID) begin
                        state_d = S_ERROR;
                        last_d  = status_code_in;
                    end
                end
                default: ;
            endcase
        end else if (in_hold) begin
            if (hold_done) begin
                state_d = session_q ? S_MENU : S_IDLE;
            end
        end else if (ready_q) begin
            case (state_q)
                S_IDLE:       state_d = S_ACC_NUM;
                S_MENU: begin
                    case (menu_option)
                        2'b00:   state_d = S_SHOW_BAL;
                        2'b01:   state_d = S_CONVERT;
                        2'b10:   state_d = S_WITHDRAW;
                        default: state_d = S_TRANSFER;
                    endcase
                end
                S_SHOW_BAL:   state_d = S_MENU;
                S_CONVERT:    state_d = S_SEL_CONV_1;
                S_SEL_CONV_2: state_d = S_SUCCESS;
                S_WITHDRAW:   state_d = S_SEL_AMT_WD;
                S_SEL_CUR_TR: state_d = S_SEL_AMT_TR;
                S_ACC_NUM, S_PIN_INPUT, S_SEL_CONV_1,
                S_SEL_AMT_WD, S_TRANSFER, S_SEL_AMT_TR: pending_d = 1'b1;
                default: ;
            endcase
        end

        if (state_d == S_IDLE) begin
            session_d = 1'b0;
            tries_d   = TRIES_INIT;
        end

        // One dwell counter serves both the inactivity timeout and the hold timer.
        if ((state_d != state_q) || (state_q == S_IDLE) || (counted && ready_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            session_q    <= 1'b0;
            tries_q      <= TRIES_INIT;
            last_q       <= 4'd0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
            ready_prev_q <= 1'b0;
            exit_prev_q  <= 1'b0;
            ready_q      <= 1'b0;
            exit_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            session_q    <= session_d;
            tries_q      <= tries_d;
            last_q       <= last_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            ready_prev_q <= ready_btn;
            exit_prev_q  <= exit_btn;
            ready_q      <= ready_btn & ~ready_prev_q;
            exit_q       <= exit_btn & ~exit_prev_q;
        end
    end

    assign current_state  = state_q;
    assign ready_out      = ready_q;
    assign session_active = session_q;
    assign pin_tries_left = tries_q;
    assign last_status    = last_q;
    assign timeout_flag   = timeout_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: each press queues the expected screen
// and bookkeeping, which the scenario pops and compares once the DUT has settled.
module tb_atm_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready_btn, exit_btn;
    logic [1:0]  menu_option;
    logic [3:0]  status_code_in;
    logic [15:0] current_state;
    logic        ready_out, session_active, timeout_flag;
    logic [1:0]  pin_tries_left;
    logic [3:0]  last_status;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [15:0] st;
        logic [1:0]  tries;
        logic        sess;
        logic [3:0]  last;
    } exp_t;

    typedef struct packed {
        logic [3:0] code;
        logic [1:0] edges;
        exp_t       exp;
    } step_t;

    exp_t sb[$];
    exp_t e;

    atm_session_ctrl #(
        .MAX_PIN_TRIES (3),
        .TIMEOUT_CYCLES(20),
        .HOLD_CYCLES   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ready_btn     (ready_btn),
        .exit_btn      (exit_btn),
        .menu_option   (menu_option),
        .status_code_in(status_code_in),
        .current_state (current_state),
        .ready_out     (ready_out),
        .session_active(session_active),
        .pin_tries_left(pin_tries_left),
        .last_status   (last_status),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] s, input logic [1:0] t,
                                input logic ss, input logic [3:0] l);
        exp_t r;
        r.st = s; r.tries = t; r.sess = ss; r.last = l;
        return r;
    endfunction

    function automatic exp_t observed();
        return mk(current_state, pin_tries_left, session_active, last_status);
    endfunction

    function automatic step_t stp(input logic [3:0] c, input logic [1:0] n, input exp_t x);
        step_t r;
        r.code = c; r.edges = n; r.exp = x;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the edge where the result should show.
    task automatic press(input logic [3:0] code, input logic [1:0] edges, input exp_t exp);
        status_code_in = code;
        ready_btn      = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        ready_btn = 1'b0;
        repeat (int'(edges) - 1) @(posedge clk);
        #1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready_btn = 1'b0; exit_btn = 1'b0;
        menu_option = 2'b00; status_code_in = 4'd0;
        wait_edges(3);
        tests_run++;
        if ({current_state, ready_out, session_active, pin_tries_left, last_status, timeout_flag}
            !== {16'h0001, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: got st=%h rdy=%b sess=%b tries=%0d last=%0d tf=%b want 0001/0/0/3/0/0",
                     current_state, ready_out, session_active, pin_tries_left, last_status, timeout_flag);
        end
        rst_n = 1'b1;
        wait_edges(1);
    endtask

    task automatic test_lockout();
        step_t steps[5];
        steps[0] = stp(4'd0, 2'd2, mk(16'h0002, 2'd3, 1'b0, 4'd0));
        steps[1] = stp(4'd1, 2'd3, mk(16'h0004, 2'd3, 1'b0, 4'd1));
        steps[2] = stp(4'd4, 2'd3, mk(16'h0004, 2'd2, 1'b0, 4'd4));
        steps[3] = stp(4'd4, 2'd3, mk(16'h0004, 2'd1, 1'b0, 4'd4));
        steps[4] = stp(4'd4, 2'd3, mk(16'h2000, 2'd0, 1'b0, 4'd4));
        foreach (steps[i]) begin
            press(steps[i].code, steps[i].edges, steps[i].exp);
            e = sb.pop_front();
            tests_run++;
            if (observed() !== e) begin
                tests_failed++;
                $display("FAIL lockout[%0d]: got %h want %h", i, observed(), e);
            end
        end
        wait_edges(3);
        tests_run++;
        if (current_state !== 16'h2000) begin
            tests_failed++;
            $display("FAIL lockout_hold: got %h want 2000", current_state);
        end
        sb.push_back(mk(16'h0001, 2'd3, 1'b0, 4'd4));
        wait_edges(1);
        e = sb.pop_front();
        tests_run++;
        if (observed() !== e) begin
            tests_failed++;
            $display("FAIL lockout_exit: got %h want %h", observed(), e);
        end
    endtask

    task automatic test_login(input logic [3:0] prev_last, input string tag);
        step_t steps[3];
        steps[0] = stp(4'd0, 2'd2, mk(16'h0002, 2'd3, 1'b0, prev_last));
        steps[1] = stp(4'd1, 2'd3, mk(16'h0004, 2'd3, 1'b0, 4'd1));
        steps[2] = stp(4'd3, 2'd3, mk(16'h0008, 2'd3, 1'b1, 4'd3));
        foreach (steps[i]) begin
            press(steps[i].code, steps[i].edges, steps[i].exp);
            e = sb.pop_front();
            tests_run++;
            if (observed() !== e) begin
                tests_failed++;
                $display("FAIL %s[%0d]: got %h want %h", tag, i, observed(), e);
            end
        end
    endtask

    task automatic test_withdraw();
        step_t steps[3];
        menu_option = 2'b10;
        for (int pass = 0; pass < 2; pass++) begin
            logic [3:0]  code = (pass == 0) ? 4'd6 : 4'd5;
            logic [15:0] fin  = (pass == 0) ? 16'h2000 : 16'h4000;
            steps[0] = stp(4'd0, 2'd2, mk(16'h0100, 2'd3, 1'b1, (pass == 0) ? 4'd3 : 4'd6));
            steps[1] = stp(4'd0, 2'd2, mk(16'h0200, 2'd3, 1'b1, (pass == 0) ? 4'd3 : 4'd6));
            steps[2] = stp(code, 2'd3, mk(fin, 2'd3, 1'b1, code));
            foreach (steps[i]) begin
                press(steps[i].code, steps[i].edges, steps[i].exp);
                e = sb.pop_front();
                tests_run++;
                if (observed() !== e) begin
                    tests_failed++;
                    $display("FAIL withdraw%0d[%0d]: got %h want %h", pass, i, observed(), e);
                end
            end
            wait_edges(3);
            tests_run++;
            if (current_state !== fin) begin
                tests_failed++;
                $display("FAIL withdraw%0d_hold: got %h want %h", pass, current_state, fin);
            end
            wait_edges(1);
            tests_run++;
            if (current_state !== 16'h0008 || session_active !== 1'b1) begin
                tests_failed++;
                $display("FAIL withdraw%0d_return: got %h sess=%b want 0008 sess=1",
                         pass, current_state, session_active);
            end
        end
    endtask

    // Entered at posedge+1 right after arriving in MENU.
    task automatic test_timeout();
        wait_edges(19);
        tests_run++;
        if (current_state !== 16'h0008 || timeout_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: got %h tf=%b want 0008 tf=0", current_state, timeout_flag);
        end
        wait_edges(1);
        tests_run++;
        if ({current_state, timeout_flag, session_active, pin_tries_left}
            !== {16'h0001, 1'b1, 1'b0, 2'd3}) begin
            tests_failed++;
            $display("FAIL timeout_fire: got %h tf=%b sess=%b tries=%0d want 0001 tf=1 sess=0 tries=3",
                     current_state, timeout_flag, session_active, pin_tries_left);
        end
        wait_edges(1);
        tests_run++;
        if (timeout_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse: got tf=%b want 0", timeout_flag);
        end
    endtask

    task automatic test_exit_priority();
        test_login(4'd5, "exit_login");
        menu_option = 2'b11;
        press(4'd0, 2'd2, mk(16'h0400, 2'd3, 1'b1, 4'd3));
        e = sb.pop_front();
        tests_run++;
        if (observed() !== e) begin
            tests_failed++;
            $display("FAIL exit_transfer: got %h want %h", observed(), e);
        end
        status_code_in = 4'd1;
        ready_btn = 1'b1;
        exit_btn  = 1'b1;
        wait_edges(1);
        ready_btn = 1'b0;
        exit_btn  = 1'b0;
        tests_run++;
        if (ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL exit_strobe: got ready_out=%b want 1", ready_out);
        end
        wait_edges(1);
        tests_run++;
        if (current_state !== 16'h0001 || session_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL exit_idle: got %h sess=%b want 0001 sess=0", current_state, session_active);
        end
        wait_edges(2);
        tests_run++;
        if (observed() !== mk(16'h0001, 2'd3, 1'b0, 4'd3) || timeout_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL exit_ignored: got %h tf=%b want %h tf=0",
                     observed(), timeout_flag, mk(16'h0001, 2'd3, 1'b0, 4'd3));
        end
    endtask

    task automatic test_reset_mid();
        test_login(4'd3, "rst_login");
        menu_option = 2'b11;
        press(4'd0, 2'd2, mk(16'h0400, 2'd3, 1'b1, 4'd3));
        press(4'd1, 2'd3, mk(16'h0800, 2'd3, 1'b1, 4'd1));
        press(4'd0, 2'd2, mk(16'h1000, 2'd3, 1'b1, 4'd1));
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            tests_run++;
            if (i == 2 && observed() !== e) begin
                tests_failed++;
                $display("FAIL rst_path: got %h want %h", observed(), e);
            end
        end
        status_code_in = 4'd5;
        ready_btn = 1'b1;
        @(posedge clk); #1;
        ready_btn = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({current_state, ready_out, pin_tries_left, last_status, session_active, timeout_flag}
            !== {16'h0001, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_async: got st=%h rdy=%b tries=%0d last=%0d sess=%b tf=%b want 0001/0/3/0/0/0",
                     current_state, ready_out, pin_tries_left, last_status, session_active, timeout_flag);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        press(4'd0, 2'd2, mk(16'h0002, 2'd3, 1'b0, 4'd0));
        press(4'd1, 2'd3, mk(16'h0004, 2'd3, 1'b0, 4'd1));
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            tests_run++;
            if (i == 1 && observed() !== e) begin
                tests_failed++;
                $display("FAIL rst_relogin: got %h want %h", observed(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lockout();
        test_login(4'd4, "login");
        test_withdraw();
        test_timeout();
        test_exit_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
